mem_port_arbiter: RTL and testbench

- Shares the single main-memory port between the I-cache refill path (read-only) and the D-cache refill/evict path (read/write).
- Sits between the cache controller request outputs and main memory.
- Latches one request at a time, drives the memory strobes until mem_rdy, returns read data with a one-cycle ack, and guards each access with a timeout.

---
 rtl/mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one main-memory port between the I-cache refill path (read only)
//   and the D-cache refill/evict path (read or write). One request is latched
//   at a time. The memory strobes stay high until mem_rdy arrives. Read data
//   comes back with a one-cycle ack. A cycle counter puts a timeout on every
//   access.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   i_req / i_addr    I-side read request and address
//   i_ack             one-cycle I-side completion pulse (rdata valid)
//   d_req / d_we      D-side request and op (1 = write/evict, 0 = read)
//   d_addr / d_wdata  D-side address and write data
//   d_ack             one-cycle D-side completion pulse (rdata valid)
//   rdata             registered read data, valid while an ack is high
//   mem_re / mem_we   memory read / write strobes
//   mem_addr          latched memory address
//   mem_wdata         latched memory write data
//   mem_rdata         memory read data, valid with mem_rdy
//   mem_rdy           memory completion, only looked at while BUSY
//   di_active         owner of the current or last transaction (0 = I, 1 = D)
//   busy              high in BUSY and RESP
//   err               sticky timeout flag, cleared only by rst
//   dbg_state_o       current FSM state (IDLE = 0, BUSY = 1, RESP = 2)
//
// Handshake (both requester sides):
//   A requester raises req with its address/data stable and holds it until
//   the matching ack pulse. The ack is high for exactly one cycle. The
//   requester lowers req on the clock edge that samples the ack. The arbiter
//   is back in IDLE only after that edge, so a held req is never granted
//   twice. Dropping req before the ack does not abort the access: it still
//   completes and is still acked. Toward memory, the strobe plays the role of
//   "valid" and mem_rdy the role of "ready": the strobe, address and data do
//   not change while the strobe is high, and the access ends on the first
//   cycle where mem_rdy is sampled high.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              di_active,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The counter holds the BUSY cycles already spent. On the cycle where it
  // reaches TIMEOUT-1, the strobe has been high for TIMEOUT cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic              mem_re_q,    mem_re_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              i_ack_q,     i_ack_d;
  logic              d_ack_q,     d_ack_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;
  logic              di_q,        di_d;
  logic              last_d_q,    last_d_d;   // last grant went to D
  logic              we_q,        we_d;       // latched op of the current access
  logic [7:0]        cnt_q,       cnt_d;

  logic grant_i;
  logic grant_d;
  logic rdy_hit;
  logic tmo_hit;

  // -------------------------------------------------------------------------
  // Arbitration. A lone requester always wins. On a tie, the side that did
  // not get the last grant wins.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_d = d_req && (!i_req || !last_d_q);
    grant_i = i_req && !grant_d;
  end

  // mem_rdy beats the timeout when both happen on the same cycle.
  always_comb begin
    rdy_hit = (state_q == ST_BUSY) && mem_rdy;
    tmo_hit = (state_q == ST_BUSY) && !mem_rdy && (cnt_q == CNT_LAST);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_i || grant_d) begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rdy_hit || tmo_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic. Every output is registered, so this block computes
  // the next value of each output register.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    di_d        = di_q;
    last_d_d    = last_d_q;
    we_d        = we_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_i || grant_d) begin
          di_d       = grant_d;
          last_d_d   = grant_d;
          // The I side is read-only, so only a D grant can make a write.
          we_d       = grant_d && d_we;
          mem_re_d   = !(grant_d && d_we);
          mem_we_d   = grant_d && d_we;
          mem_addr_d = grant_d ? d_addr : i_addr;
          if (grant_d) begin
            mem_wdata_d = d_wdata;
          end
          busy_d = 1'b1;
          cnt_d  = 8'd0;
        end
      end

      ST_BUSY: begin
        // Cannot wrap: BUSY is left no later than when cnt_q == TIMEOUT-1.
        cnt_d = cnt_q + 8'd1;
        if (rdy_hit) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          i_ack_d  = !di_q;
          d_ack_d  = di_q;
        end else if (tmo_hit) begin
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          err_d    = 1'b1;
          rdata_d  = '0;
          i_ack_d  = !di_q;
          d_ack_d  = di_q;
        end
      end

      ST_RESP: begin
        busy_d = 1'b0;
      end

      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      di_q        <= 1'b0;
      last_d_q    <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      di_q        <= di_d;
      last_d_q    <= last_d_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;
  assign i_ack       = i_ack_q;
  assign d_ack       = d_ack_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign di_active   = di_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Testbench for mem_port_arbiter with TIMEOUT = 4. It contains a memory
// responder with a programmable ready delay, a request engine that records
// acks and strobe episodes, and a transaction-level reference model. Checks
// come from a table of hand-computed vectors, hand-written tie and reset
// sequences, and randomized traffic.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_ack, d_ack;
  logic [DW-1:0] rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic          di_active, busy, err;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .di_active(di_active), .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory contents that were never written.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {2'b10, 16'h0000, a} ^ 32'h1357_0000;
  endfunction

  // ---------------- memory responder ----------------
  // rdy_delay = n > 0: mem_rdy is raised on the n-th cycle the strobe is high.
  // rdy_delay = 0: memory never answers. While the strobe is low, mem_rdy
  // and mem_rdata carry noise that the arbiter must ignore.
  int            rdy_delay = 1;
  int            strb_cnt  = 0;
  logic [DW-1:0] phys_mem [logic [AW-1:0]];

  initial begin
    mem_rdy   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (mem_re || mem_we) begin
        mem_rdy = 1'b0;
        strb_cnt++;
        if (rdy_delay != 0 && strb_cnt == rdy_delay) begin
          mem_rdy = 1'b1;
          if (mem_we) phys_mem[mem_addr] = mem_wdata;
          else mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
        end
      end else begin
        strb_cnt = 0;
        mem_rdy  = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- observed / expected records ----------------
  typedef struct {
    bit            side;
    int            cyc;
    logic [DW-1:0] rdata;
    bit            err;
    bit            di;
    bit            both;
    bit            bsy;
  } ack_t;

  typedef struct {
    bit            re;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            len;
    bit            stable;
  } strb_t;

  ack_t          acks[$];
  strb_t         strbs[$];
  bit            eng_to;
  bit            post_idle;

  ack_t          exp_acks[$];
  strb_t         exp_strbs[$];
  logic [DW-1:0] exp_q[$];

  // ---------------- driver / request engine ----------------
  // Start this task just after a rising edge. Requests are held until their
  // ack is seen, then lowered on the edge that samples the ack.
  task automatic run_txns(input bit ien, input logic [AW-1:0] ia, input bit den,
                          input bit dwe, input logic [AW-1:0] da,
                          input logic [DW-1:0] dwd, input int dly);
    int    cyc = 0;
    bit    ip  = ien;
    bit    dp  = den;
    bit    ins = 1'b0;
    bit    sa_i, sa_d;
    strb_t cur;
    ack_t  a;
    acks.delete();
    strbs.delete();
    eng_to    = 1'b0;
    rdy_delay = dly;
    i_addr = ia; d_we = dwe; d_addr = da; d_wdata = dwd;
    i_req  = ien; d_req = den;
    while (ip || dp || ins) begin
      if (cyc >= 60) begin
        eng_to = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
      if (mem_re || mem_we) begin
        if (!ins) begin
          cur.re = mem_re; cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
          cur.len = 0; cur.stable = 1'b1; ins = 1'b1;
        end else if (mem_re !== cur.re || mem_we !== cur.we ||
                     mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
          cur.stable = 1'b0;
        end
        if (busy !== 1'b1) cur.stable = 1'b0;
        cur.len++;
      end else if (ins) begin
        strbs.push_back(cur);
        ins = 1'b0;
      end
      if (i_ack || d_ack) begin
        a.side = d_ack; a.cyc = cyc; a.rdata = rdata; a.err = err;
        a.di = di_active; a.both = i_ack && d_ack; a.bsy = busy;
        acks.push_back(a);
        sa_i = i_ack; sa_d = d_ack;
        @(posedge clk);
        #1;
        if (sa_i) begin i_req = 1'b0; ip = 1'b0; end
        if (sa_d) begin d_req = 1'b0; dp = 1'b0; end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    post_idle = !i_ack && !d_ack && !busy && !mem_re && !mem_we;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Works per transaction. The tie winner is the side opposite the last
  // grant. A transaction lasts its memory time plus two cycles (grant and
  // ack), measured from the previous ack or from the request.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit            m_last_d;
  bit            m_err;
  logic [DW-1:0] m_rdata;

  function automatic void model_reset();
    m_last_d = 1'b0;
    m_err    = 1'b0;
    m_rdata  = '0;
  endfunction

  function automatic void model_one(input bit side, input bit we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] wdata, input int dly, inout int t);
    bit    tmo  = (dly == 0) || (dly > TMO);
    int    span = tmo ? TMO : dly;
    strb_t s;
    ack_t  a;
    s.re = !we; s.we = we; s.addr = addr; s.wdata = wdata; s.len = span; s.stable = 1'b1;
    exp_strbs.push_back(s);
    if (tmo) begin
      m_rdata = '0;
      m_err   = 1'b1;
    end else if (we) begin
      ref_mem[addr] = wdata;
    end else begin
      m_rdata = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    end
    t += span + 2;
    a.side = side; a.cyc = t; a.rdata = m_rdata; a.err = m_err; a.di = side;
    a.both = 1'b0; a.bsy = 1'b1;
    exp_acks.push_back(a);
    exp_q.push_back(m_rdata);
    m_last_d = side;
  endfunction

  function automatic void model_txns(input bit ien, input logic [AW-1:0] ia, input bit den,
                                     input bit dwe, input logic [AW-1:0] da,
                                     input logic [DW-1:0] dwd, input int dly);
    int t = 0;
    exp_acks.delete();
    exp_strbs.delete();
    exp_q.delete();
    if (ien && den) begin
      if (!m_last_d) begin
        model_one(1'b1, dwe, da, dwd, dly, t);
        model_one(1'b0, 1'b0, ia, '0, dly, t);
      end else begin
        model_one(1'b0, 1'b0, ia, '0, dly, t);
        model_one(1'b1, dwe, da, dwd, dly, t);
      end
    end else if (den) begin
      model_one(1'b1, dwe, da, dwd, dly, t);
    end else if (ien) begin
      model_one(1'b0, 1'b0, ia, '0, dly, t);
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_run(input string tag);
    chk({tag, " finished"}, 64'(eng_to), 64'(0));
    chk({tag, " ack count"}, 64'(acks.size()), 64'(exp_acks.size()));
    for (int i = 0; i < exp_acks.size() && i < acks.size(); i++) begin
      chk($sformatf("%s ack%0d side", tag, i), 64'(acks[i].side), 64'(exp_acks[i].side));
      chk($sformatf("%s ack%0d cycle", tag, i), 64'(acks[i].cyc), 64'(exp_acks[i].cyc));
      chk($sformatf("%s ack%0d rdata", tag, i), 64'(acks[i].rdata), 64'(exp_q[i]));
      chk($sformatf("%s ack%0d err", tag, i), 64'(acks[i].err), 64'(exp_acks[i].err));
      chk($sformatf("%s ack%0d di_active", tag, i), 64'(acks[i].di), 64'(exp_acks[i].di));
      chk($sformatf("%s ack%0d single", tag, i), 64'(acks[i].both), 64'(0));
      chk($sformatf("%s ack%0d busy", tag, i), 64'(acks[i].bsy), 64'(1));
    end
    chk({tag, " strobe count"}, 64'(strbs.size()), 64'(exp_strbs.size()));
    for (int i = 0; i < exp_strbs.size() && i < strbs.size(); i++) begin
      chk($sformatf("%s strb%0d re", tag, i), 64'(strbs[i].re), 64'(exp_strbs[i].re));
      chk($sformatf("%s strb%0d we", tag, i), 64'(strbs[i].we), 64'(exp_strbs[i].we));
      chk($sformatf("%s strb%0d addr", tag, i), 64'(strbs[i].addr), 64'(exp_strbs[i].addr));
      chk($sformatf("%s strb%0d len", tag, i), 64'(strbs[i].len), 64'(exp_strbs[i].len));
      chk($sformatf("%s strb%0d stable", tag, i), 64'(strbs[i].stable), 64'(1));
      if (exp_strbs[i].we)
        chk($sformatf("%s strb%0d wdata", tag, i), 64'(strbs[i].wdata), 64'(exp_strbs[i].wdata));
    end
    chk({tag, " idle after"}, 64'(post_idle), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic run_both(input string tag, input bit ien, input logic [AW-1:0] ia,
                          input bit den, input bit dwe, input logic [AW-1:0] da,
                          input logic [DW-1:0] dwd, input int dly);
    model_txns(ien, ia, den, dwe, da, dwd, dly);
    run_txns(ien, ia, den, dwe, da, dwd, dly);
    check_run(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            side;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            dly;
    logic [DW-1:0] e_rdata;
    bit            e_err;
    int            e_cyc;
    int            e_len;
  } vec_t;

  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    bit            ien, den, dwe, side, both;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd;
    int            dly, gap;
    bit            no_ack;

    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    phys_mem[14'h0123] = 32'hDEAD_BEEF; ref_mem[14'h0123] = 32'hDEAD_BEEF;
    phys_mem[14'h0200] = 32'hCAFE_F00D; ref_mem[14'h0200] = 32'hCAFE_F00D;

    // Reset values appear before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("reset mem_re", 64'(mem_re), 64'(0));
    chk("reset mem_we", 64'(mem_we), 64'(0));
    chk("reset i_ack", 64'(i_ack), 64'(0));
    chk("reset d_ack", 64'(d_ack), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    chk("reset di_active", 64'(di_active), 64'(0));
    chk("reset mem_addr", 64'(mem_addr), 64'(0));
    chk("reset mem_wdata", 64'(mem_wdata), 64'(0));
    chk("reset rdata", 64'(rdata), 64'(0));
    chk("reset state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // side, we, addr, wdata, dly, exp rdata, exp err, exp ack cycle, exp strobe len
    vecs[0] = '{1'b0, 1'b0, 14'h0123, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 5, 3};
    vecs[1] = '{1'b1, 1'b1, 14'h3F00, 32'h1234_5678, 1, 32'hDEAD_BEEF, 1'b0, 3, 1};
    vecs[2] = '{1'b1, 1'b0, 14'h3F00, 32'h0,         2, 32'h1234_5678, 1'b0, 4, 2};
    vecs[3] = '{1'b0, 1'b0, 14'h0200, 32'h0,         4, 32'hCAFE_F00D, 1'b0, 6, 4};
    vecs[4] = '{1'b1, 1'b0, 14'h0055, 32'h0,         0, 32'h0,         1'b1, 6, 4};
    vecs[5] = '{1'b0, 1'b0, 14'h0123, 32'h0,         1, 32'hDEAD_BEEF, 1'b1, 3, 1};
    vecs[6] = '{1'b1, 1'b1, 14'h0300, 32'hA5A5_A5A5, 2, 32'hDEAD_BEEF, 1'b1, 4, 2};

    for (int v = 0; v < 7; v++) begin
      string tag = $sformatf("vec%0d", v);
      run_both(tag, !vecs[v].side, vecs[v].addr, vecs[v].side, vecs[v].we,
               vecs[v].addr, vecs[v].wdata, vecs[v].dly);
      chk({tag, " acked once"}, 64'(acks.size()), 64'(1));
      if (acks.size() > 0) begin
        chk({tag, " table rdata"}, 64'(acks[0].rdata), 64'(vecs[v].e_rdata));
        chk({tag, " table err"}, 64'(acks[0].err), 64'(vecs[v].e_err));
        chk({tag, " table cycle"}, 64'(acks[0].cyc), 64'(vecs[v].e_cyc));
        chk({tag, " table di"}, 64'(acks[0].di), 64'(vecs[v].side));
      end
      if (strbs.size() > 0)
        chk({tag, " table len"}, 64'(strbs[0].len), 64'(vecs[v].e_len));
    end

    // Ties: D wins the first one after reset; after a D grant, I wins.
    do_reset();
    chk("post-reset err clear", 64'(err), 64'(0));
    run_both("tie1", 1'b1, 14'h0123, 1'b1, 1'b0, 14'h3F00, 32'h0, 1);
    if (acks.size() == 2) begin
      chk("tie1 first is D", 64'(acks[0].side), 64'(1));
      chk("tie1 gap", 64'(acks[1].cyc - acks[0].cyc), 64'(3));
    end
    run_both("solo D", 1'b0, 14'h0, 1'b1, 1'b1, 14'h0400, 32'h0BAD_CAFE, 1);
    run_both("tie2", 1'b1, 14'h0400, 1'b1, 1'b0, 14'h0123, 32'h0, 2);
    if (acks.size() == 2) chk("tie2 first is I", 64'(acks[0].side), 64'(0));

    // Reset in the middle of a D access that memory never answers.
    rdy_delay = 0;
    d_we = 1'b0; d_addr = 14'h0066; d_req = 1'b1;
    for (int i = 0; i < 10 && !(mem_re || mem_we); i++) @(negedge clk);
    chk("rstmid strobe up", 64'(mem_re), 64'(1));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid mem_re async", 64'(mem_re), 64'(0));
    chk("rstmid mem_we async", 64'(mem_we), 64'(0));
    chk("rstmid busy async", 64'(busy), 64'(0));
    chk("rstmid state async", 64'(dbg_state), 64'(0));
    d_req = 1'b0;
    no_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i_ack || d_ack) no_ack = 1'b0;
    end
    chk("rstmid no ack", 64'(no_ack), 64'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i_ack || d_ack || busy) no_ack = 1'b0;
    end
    chk("rstmid quiet after", 64'(no_ack), 64'(1));
    @(posedge clk);
    #1;
    run_both("tie3", 1'b1, 14'h0123, 1'b1, 1'b0, 14'h0200, 32'h0, 1);
    if (acks.size() == 2) chk("tie3 first is D", 64'(acks[0].side), 64'(1));

    // Randomized traffic against the reference model.
    for (int it = 0; it < 40; it++) begin
      if (it == 20) do_reset();
      both = ($urandom_range(0, 3) == 0);
      side = 1'($urandom_range(0, 1));
      ien  = both || !side;
      den  = both || side;
      dwe  = 1'($urandom_range(0, 1));
      ia   = AW'($urandom_range(0, 15));
      da   = AW'($urandom_range(0, 15));
      dwd  = $urandom;
      dly  = $urandom_range(0, 5);
      gap  = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      run_both($sformatf("rnd%0d", it), ien, ia, den, dwe, da, dwd, dly);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule
